// File: rtl/compare_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : compare_arbiter
// Description : Round-robin scheduler sharing one external equality
//               comparator among N requesters. A grant latches the winner's
//               operand pair, the comparator result is sampled one cycle
//               later and returned with a one-cycle one-hot ack.
//               Optional macro MISMATCH_CNT_EN adds a saturating 8-bit
//               mismatch counter output (mism_cnt).
// Revision    : 1.0  initial release
// ============================================================================
module compare_arbiter #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [N*W-1:0]         a_bus,
  input  logic [N*W-1:0]         b_bus,
  output logic [N-1:0]           ack,
  output logic                   eq,
  output logic                   busy,
  output logic [$clog2(N)-1:0]   gnt_id,
  output logic [W-1:0]           cmp_a,
  output logic [W-1:0]           cmp_b,
  input  logic                   cmp_eq
`ifdef MISMATCH_CNT_EN
  ,
  output logic [7:0]             mism_cnt
`endif
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  gnt_id_q, gnt_id_d;
  logic [W-1:0]   cmp_a_q, cmp_a_d;
  logic [W-1:0]   cmp_b_q, cmp_b_d;
  logic           eq_q, eq_d;
  logic           busy_q, busy_d;
  logic [N-1:0]   ack_q, ack_d;
`ifdef MISMATCH_CNT_EN
  logic [7:0]     mism_cnt_q, mism_cnt_d;
`endif

  logic           sel_found;
  logic [PW-1:0]  sel_idx;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;

  // Round-robin pick: first requester at or after ptr, wrapping modulo N.
  always_comb begin
    int            c;
    logic [PW-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    c         = 0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      c = int'(ptr_q) + off;
      if (c >= N) c = c - N;
      cand = PW'(c);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Operand slice mux for the selected requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (PW'(i) == sel_idx) begin
        sel_a = a_bus[i*W +: W];
        sel_b = b_bus[i*W +: W];
      end
    end
  end

  // Next-state and next-output logic for the IDLE -> CMP -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    cmp_a_d  = cmp_a_q;
    cmp_b_d  = cmp_b_q;
    eq_d     = eq_q;
    busy_d   = busy_q;
    ack_d    = '0;
`ifdef MISMATCH_CNT_EN
    mism_cnt_d = mism_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          gnt_id_d = sel_idx;
          cmp_a_d  = sel_a;
          cmp_b_d  = sel_b;
          busy_d   = 1'b1;
          state_d  = S_CMP;
        end
      end
      S_CMP: begin
        // Ack is registered so it is high for exactly the DONE cycle.
        eq_d    = cmp_eq;
        busy_d  = 1'b1;
        state_d = S_DONE;
        for (int i = 0; i < N; i++) begin
          ack_d[i] = (PW'(i) == gnt_id_q);
        end
      end
      S_DONE: begin
        // Winner moves to the back of the rotation.
        ptr_d   = (gnt_id_q == PW'(N-1)) ? '0 : gnt_id_q + PW'(1);
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef MISMATCH_CNT_EN
        if (!eq_q && (mism_cnt_q != 8'hFF)) mism_cnt_d = mism_cnt_q + 8'd1;
`endif
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
      eq_q     <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
`ifdef MISMATCH_CNT_EN
      mism_cnt_q <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      cmp_a_q  <= cmp_a_d;
      cmp_b_q  <= cmp_b_d;
      eq_q     <= eq_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
`ifdef MISMATCH_CNT_EN
      mism_cnt_q <= mism_cnt_d;
`endif
    end
  end

  assign ack    = ack_q;
  assign eq     = eq_q;
  assign busy   = busy_q;
  assign gnt_id = gnt_id_q;
  assign cmp_a  = cmp_a_q;
  assign cmp_b  = cmp_b_q;
`ifdef MISMATCH_CNT_EN
  assign mism_cnt = mism_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_compare_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_compare_arbiter
// Description : Self-checking bench for compare_arbiter. A timeline model of
//               grants (grant edge, ack one edge later, idle two edges later)
//               predicts every output each cycle. Honours MISMATCH_CNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_compare_arbiter;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int PW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   a_bus = '0;
  logic [N*W-1:0]   b_bus = '0;
  logic [N-1:0]     ack;
  logic             eq;
  logic             busy;
  logic [PW-1:0]    gnt_id;
  logic [W-1:0]     cmp_a;
  logic [W-1:0]     cmp_b;
  logic             cmp_eq;
`ifdef MISMATCH_CNT_EN
  logic [7:0]       mism_cnt;
`endif

  // The shared external comparator.
  assign cmp_eq = (cmp_a == cmp_b);

  compare_arbiter #(.N(N), .W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .a_bus  (a_bus),
    .b_bus  (b_bus),
    .ack    (ack),
    .eq     (eq),
    .busy   (busy),
    .gnt_id (gnt_id),
    .cmp_a  (cmp_a),
    .cmp_b  (cmp_b),
    .cmp_eq (cmp_eq)
`ifdef MISMATCH_CNT_EN
    ,
    .mism_cnt (mism_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: one outstanding op described by its grant edge.
  int edge_n   = 0;
  bit m_active = 0;
  int m_g      = 0;
  int m_ptr    = 0;
  int m_gnt    = 0;
  int m_a      = 0;
  int m_b      = 0;
  int m_cnt    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_ptr    = 0;
    m_gnt    = 0;
    m_a      = 0;
    m_b      = 0;
    m_cnt    = 0;
  endtask

  task automatic model_edge();
    int  w;
    bit  found;
    if (reset) begin
      model_reset();
    end else if (m_active && edge_n == m_g + 2) begin
      if (m_a != m_b && m_cnt < 255) m_cnt++;
      m_active = 0;
    end else if (!m_active && req != 0) begin
      found = 0;
      w     = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && req[(m_ptr + i) % N]) begin
          found = 1;
          w     = (m_ptr + i) % N;
        end
      end
      m_gnt    = w;
      m_a      = int'((a_bus >> (w * W)) & ((1 << W) - 1));
      m_b      = int'((b_bus >> (w * W)) & ((1 << W) - 1));
      m_g      = edge_n;
      m_active = 1;
      m_ptr    = (w + 1) % N;
    end
  endtask

  task automatic check_outputs();
    int exp_ack;
    exp_ack = (m_active && edge_n == m_g + 1) ? (1 << m_gnt) : 0;
    check_val("ack",    32'(ack),    32'(exp_ack));
    check_val("busy",   32'(busy),   32'(m_active));
    check_val("gnt_id", 32'(gnt_id), 32'(m_gnt));
    check_val("cmp_a",  32'(cmp_a),  32'(m_a));
    check_val("cmp_b",  32'(cmp_b),  32'(m_b));
    if (exp_ack != 0) check_val("eq", 32'(eq), 32'(m_a == m_b));
`ifdef MISMATCH_CNT_EN
    check_val("mism_cnt", 32'(mism_cnt), 32'(m_cnt));
`endif
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    req   = r;
    a_bus = a;
    b_bus = b;
    @(posedge clk);
    edge_n++;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_eq", 32'(eq), 32'd0);
    step('0, '0, '0);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, a_bus, b_bus);
  endtask

  initial begin
    logic [N*W-1:0] ra;
    logic [N*W-1:0] rb;

    @(negedge clk);
    model_reset();
    check_outputs();
    check_val("rst_eq", 32'(eq), 32'd0);
    step('0, '0, '0);
    reset = 1'b0;

    // Single matching op on requester 0.
    step(4'b0001, 12'o0005, 12'o0005);
    idle(3);
    // Mismatch on requester 2.
    step(4'b0100, 12'o0600, 12'o0200);
    idle(3);
    // Operand change after grant is ignored.
    step(4'b0010, 12'o0030, 12'o0030);
    step(4'b0000, 12'o0000, 12'o0030);
    idle(3);

    // Fairness from ptr=0 with all requesting.
    do_reset();
    for (int i = 0; i < 12; i++) step(4'b1111, 12'($urandom), 12'($urandom));
    idle(3);

    // Reset while in CMP: immediate clear, no ack, then fresh scan from 0.
    step(4'b0001, 12'o0007, 12'o0007);
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    do_reset();
    step(4'b0010, 12'o0040, 12'o0040);
    idle(3);

    // Randomised traffic; operands often equal so both eq outcomes occur.
    for (int i = 0; i < 400; i++) begin
      ra = 12'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? ra : 12'($urandom);
      step(4'($urandom_range(0, 15) & $urandom_range(0, 15)), ra, rb);
    end
    idle(3);

`ifdef MISMATCH_CNT_EN
    // Saturation: 260 mismatching ops on requester 0.
    do_reset();
    for (int i = 0; i < 260 * 3; i++) step(4'b0001, 12'o0001, 12'o0002);
    idle(3);
    check_val("mism_sat", 32'(mism_cnt), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
